// File: rtl/cpu_param.sv
// cpu_param: parametrised accumulator CPU with Z/C flags, jumps and a UART echo path.
// Fetch/decode/execute runs against a synchronous RAM whose read latency is MEM_LAT cycles.
module cpu_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] startaddr,
    input  logic [DATA_W-1:0] dread,
    output logic [ADDR_W-1:0] c_raddr,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [DATA_W-1:0] dwrite,
    output logic              write_en,
    output logic              led,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              is_transmitting,
    output logic              halted,
    output logic [DATA_W-1:0] acc,
    output logic [1:0]        flags
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [7:0] OP_HLT  = 8'h00;
    localparam logic [7:0] OP_OUTA = 8'h01;
    localparam logic [7:0] OP_INCA = 8'h02;
    localparam logic [7:0] OP_DECA = 8'h03;
    localparam logic [7:0] OP_NOTA = 8'h04;
    localparam logic [7:0] OP_CLC  = 8'h05;
    localparam logic [7:0] OP_LDAI = 8'h80;
    localparam logic [7:0] OP_LDAM = 8'h84;
    localparam logic [7:0] OP_STA  = 8'h88;
    localparam logic [7:0] OP_ADD  = 8'h8C;
    localparam logic [7:0] OP_ADC  = 8'h90;
    localparam logic [7:0] OP_JMP  = 8'h94;
    localparam logic [7:0] OP_JZ   = 8'h98;
    localparam logic [7:0] OP_JC   = 8'h9C;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_OPLOAD, S_DECODE, S_WAIT2,
        S_OPLOAD2, S_EXEC, S_WAIT3, S_MEMLOAD, S_ECHO
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic              r_c;
    logic              r_z;
    logic [7:0]        r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_dwrite;
    logic              r_we;
    logic [7:0]        r_txbyte;
    logic              r_tx;
    logic              r_halted;

    logic [DATA_W:0]   w_inc;
    logic [DATA_W:0]   w_dec;
    logic [DATA_W:0]   w_add;
    logic [DATA_W-1:0] w_not;
    logic [ADDR_W-1:0] w_opaddr;

    // Operand used as an address is truncated or zero-extended to the PC width.
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
        assign w_opaddr = r_operand[ADDR_W-1:0];
    end else begin : g_addr_ext
        assign w_opaddr = {{(ADDR_W - DATA_W){1'b0}}, r_operand};
    end

    always_comb begin
        w_inc = {1'b0, r_a} + (DATA_W+1)'(1);
        w_dec = {1'b0, r_a} - (DATA_W+1)'(1);
        w_not = ~r_a;
        w_add = {1'b0, r_a} + {1'b0, r_operand}
              + {{DATA_W{1'b0}}, (r_opcode == OP_ADC) && r_c};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_pc      <= '0;
            r_a       <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_dwrite  <= '0;
            r_we      <= 1'b0;
            r_txbyte  <= '0;
            r_tx      <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_tx <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc     <= startaddr;
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_raddr <= r_pc;
                    r_wait  <= CNT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) r_state <= S_OPLOAD;
                    else              r_wait  <= r_wait - CNT_W'(1);
                end
                S_OPLOAD: begin
                    r_opcode <= dread[7:0];
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_state  <= S_DECODE;
                end
                S_DECODE: begin
                    r_raddr <= r_pc;
                    if (r_opcode == OP_HLT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (r_opcode[7]) begin
                        r_wait  <= CNT_LOAD;
                        r_state <= S_WAIT2;
                    end else begin
                        r_state <= S_FETCH;
                        case (r_opcode)
                            OP_OUTA: r_state <= S_ECHO;
                            OP_INCA: begin
                                r_a <= w_inc[DATA_W-1:0];
                                r_c <= w_inc[DATA_W];
                                r_z <= (w_inc[DATA_W-1:0] == '0);
                            end
                            OP_DECA: begin
                                r_a <= w_dec[DATA_W-1:0];
                                r_c <= w_dec[DATA_W];
                                r_z <= (w_dec[DATA_W-1:0] == '0);
                            end
                            OP_NOTA: begin
                                r_a <= w_not;
                                r_z <= (w_not == '0);
                            end
                            OP_CLC:  r_c <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_WAIT2: begin
                    if (r_wait == '0) r_state <= S_OPLOAD2;
                    else              r_wait  <= r_wait - CNT_W'(1);
                end
                S_OPLOAD2: begin
                    r_operand <= dread;
                    r_pc      <= r_pc + ADDR_W'(1);
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (r_opcode)
                        OP_LDAI: begin
                            r_a <= r_operand;
                            r_z <= (r_operand == '0);
                        end
                        OP_LDAM: begin
                            r_raddr <= w_opaddr;
                            r_wait  <= CNT_LOAD;
                            r_state <= S_WAIT3;
                        end
                        OP_STA: begin
                            r_waddr  <= w_opaddr;
                            r_dwrite <= r_a;
                            r_we     <= 1'b1;
                        end
                        OP_ADD, OP_ADC: begin
                            r_a <= w_add[DATA_W-1:0];
                            r_c <= w_add[DATA_W];
                            r_z <= (w_add[DATA_W-1:0] == '0);
                        end
                        OP_JMP: r_pc <= w_opaddr;
                        OP_JZ:  if (r_z) r_pc <= w_opaddr;
                        OP_JC:  if (r_c) r_pc <= w_opaddr;
                        default: ;
                    endcase
                end
                S_WAIT3: begin
                    if (r_wait == '0) r_state <= S_MEMLOAD;
                    else              r_wait  <= r_wait - CNT_W'(1);
                end
                S_MEMLOAD: begin
                    r_a     <= dread;
                    r_z     <= (dread == '0);
                    r_state <= S_FETCH;
                end
                S_ECHO: begin
                    if (!is_transmitting) begin
                        r_txbyte <= r_a[7:0];
                        r_tx     <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign c_raddr  = r_raddr;
    assign c_waddr  = r_waddr;
    assign dwrite   = r_dwrite;
    assign write_en = r_we;
    assign led      = (r_state != S_IDLE);
    assign tx_byte  = r_txbyte;
    assign transmit = r_tx;
    assign halted   = r_halted;
    assign acc      = r_a;
    assign flags    = {r_c, r_z};

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: a default 8/9/1 core and a 16/10/2 core, each with
// its own synchronous RAM model; expectations are hand-computed per program.
module tb_cpu_param;

    logic clk;

    logic       rst_a, start_a, busy_a, we_a, led_a, tx_a, halted_a;
    logic [8:0] saddr_a, raddr_a, waddr_a;
    logic [7:0] dread_a, dwrite_a, txb_a, acc_a;
    logic [1:0] flags_a;

    logic        rst_b, start_b, busy_b, we_b, led_b, tx_b, halted_b;
    logic [9:0]  saddr_b, raddr_b, waddr_b;
    logic [15:0] dread_b, dwrite_b, acc_b, pipe_b;
    logic [7:0]  txb_b;
    logic [1:0]  flags_b;

    logic        ld_a_en, ld_b_en;
    logic [8:0]  ld_a_addr;
    logic [7:0]  ld_a_data;
    logic [9:0]  ld_b_addr;
    logic [15:0] ld_b_data;

    logic [7:0]  mem_a [0:511];
    logic [15:0] mem_b [0:1023];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int tx_cnt_a = 0;
    int wr_cnt_a = 0;
    logic [7:0] last_tx_a = 8'h00;

    cpu_param #(.DATA_W(8), .ADDR_W(9), .MEM_LAT(1)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .startaddr(saddr_a), .dread(dread_a),
        .c_raddr(raddr_a), .c_waddr(waddr_a), .dwrite(dwrite_a), .write_en(we_a),
        .led(led_a), .tx_byte(txb_a), .transmit(tx_a), .is_transmitting(busy_a),
        .halted(halted_a), .acc(acc_a), .flags(flags_a)
    );

    cpu_param #(.DATA_W(16), .ADDR_W(10), .MEM_LAT(2)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .startaddr(saddr_b), .dread(dread_b),
        .c_raddr(raddr_b), .c_waddr(waddr_b), .dwrite(dwrite_b), .write_en(we_b),
        .led(led_b), .tx_byte(txb_b), .transmit(tx_b), .is_transmitting(busy_b),
        .halted(halted_b), .acc(acc_b), .flags(flags_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_a_en)   mem_a[ld_a_addr] <= ld_a_data;
        else if (we_a) mem_a[waddr_a]   <= dwrite_a;
        dread_a <= mem_a[raddr_a];
    end

    always @(posedge clk) begin
        if (ld_b_en)   mem_b[ld_b_addr] <= ld_b_data;
        else if (we_b) mem_b[waddr_b]   <= dwrite_b;
        pipe_b  <= mem_b[raddr_b];
        dread_b <= pipe_b;
    end

    always @(posedge clk) begin
        if (tx_a) begin
            tx_cnt_a++;
            last_tx_a = txb_a;
        end
        if (we_a) wr_cnt_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_a(input logic [8:0] base, input int n, input logic [79:0] bytes);
        for (int i = 0; i < n; i++) begin
            ld_a_en   = 1'b1;
            ld_a_addr = base + 9'(i);
            ld_a_data = bytes[8*(n-1-i) +: 8];
            tick(1);
        end
        ld_a_en = 1'b0;
    endtask

    task automatic load_b(input logic [9:0] addr, input logic [15:0] data);
        ld_b_en   = 1'b1;
        ld_b_addr = addr;
        ld_b_data = data;
        tick(1);
        ld_b_en = 1'b0;
    endtask

    task automatic go_a(input logic [8:0] addr);
        saddr_a = addr;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [9:0] addr);
        saddr_b = addr;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
    endtask

    // Counts edges until the core is back in IDLE with halted set.
    task automatic run_halt(input bit use_b, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!(use_b ? (halted_b && !led_b) : (halted_a && !led_a)) && cyc < budget);
    endtask

    initial begin
        int cyc;
        int tx0;
        int wr0;
        clk = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        saddr_a = '0; saddr_b = '0;
        busy_a = 1'b0; busy_b = 1'b0;
        ld_a_en = 1'b0; ld_a_addr = '0; ld_a_data = '0;
        ld_b_en = 1'b0; ld_b_addr = '0; ld_b_data = '0;

        tick(3);
        chk("rst_raddr",  32'(raddr_a),  0);
        chk("rst_waddr",  32'(waddr_a),  0);
        chk("rst_dwrite", 32'(dwrite_a), 0);
        chk("rst_we",     32'(we_a),     0);
        chk("rst_led",    32'(led_a),    0);
        chk("rst_txbyte", 32'(txb_a),    0);
        chk("rst_tx",     32'(tx_a),     0);
        chk("rst_halted", 32'(halted_a), 0);
        chk("rst_acc",    32'(acc_a),    0);
        chk("rst_flags",  32'(flags_a),  0);
        rst_a = 1'b1; rst_b = 1'b1;

        load_a(9'h010, 8, 80'h80058C0388400100);
        load_a(9'h040, 1, 80'h00);
        load_a(9'h000, 6, 80'h80FF029C2000);
        load_a(9'h020, 2, 80'h0100);
        load_a(9'h080, 6, 80'h800198300100);
        load_a(9'h030, 1, 80'h00);
        load_a(9'h0A0, 2, 80'h0100);
        load_a(9'h0C0, 10, 80'h80000390010405900200);
        load_a(9'h0E0, 5, 80'h80AA885000);
        load_a(9'h050, 1, 80'h11);

        // LDA#, ADD#, STA, OUTA, HLT: 7+7+7+5+4 cycles
        tx0 = tx_cnt_a; wr0 = wr_cnt_a;
        go_a(9'h010);
        run_halt(1'b0, 200, cyc);
        chk("p1_cycles", 32'(cyc), 30);
        chk("p1_halted", 32'(halted_a), 1);
        chk("p1_led", 32'(led_a), 0);
        chk("p1_acc", 32'(acc_a), 'h08);
        chk("p1_flags", 32'(flags_a), 0);
        chk("p1_mem40", 32'(mem_a[9'h040]), 'h08);
        chk("p1_writes", 32'(wr_cnt_a - wr0), 1);
        chk("p1_txcount", 32'(tx_cnt_a - tx0), 1);
        chk("p1_txbyte", 32'(last_tx_a), 'h08);
        chk("p1_raddr", 32'(raddr_a), 'h018);
        chk("p1_waddr", 32'(waddr_a), 'h040);

        // LDA# FF, INCA, JC taken, OUTA, HLT: 7+4+7+5+4
        tx0 = tx_cnt_a;
        go_a(9'h000);
        run_halt(1'b0, 200, cyc);
        chk("p2_cycles", 32'(cyc), 27);
        chk("p2_acc", 32'(acc_a), 'h00);
        chk("p2_flags", 32'(flags_a), 'b11);
        chk("p2_txcount", 32'(tx_cnt_a - tx0), 1);
        chk("p2_txbyte", 32'(last_tx_a), 'h00);
        chk("p2_raddr", 32'(raddr_a), 'h022);

        // JZ not taken; a taken jump would hit the HLT at 0x30 without transmitting
        tx0 = tx_cnt_a;
        go_a(9'h080);
        run_halt(1'b0, 200, cyc);
        chk("p3_cycles", 32'(cyc), 23);
        chk("p3_acc", 32'(acc_a), 'h01);
        chk("p3_flags", 32'(flags_a), 'b10);
        chk("p3_txcount", 32'(tx_cnt_a - tx0), 1);
        chk("p3_txbyte", 32'(last_tx_a), 'h01);
        chk("p3_raddr", 32'(raddr_a), 'h086);

        tx0 = tx_cnt_a;
        busy_a = 1'b1;
        go_a(9'h0A0);
        tick(20);
        chk("bp_no_tx", 32'(tx_cnt_a - tx0), 0);
        chk("bp_led", 32'(led_a), 1);
        busy_a = 1'b0;
        run_halt(1'b0, 200, cyc);
        chk("bp_cycles", 32'(cyc), 5);
        chk("bp_txcount", 32'(tx_cnt_a - tx0), 1);
        chk("bp_txbyte", 32'(last_tx_a), 'h01);

        // LDA#00, DECA, ADC#01, NOTA, CLC, ADC#02, HLT
        go_a(9'h0C0);
        run_halt(1'b0, 200, cyc);
        chk("p4_cycles", 32'(cyc), 37);
        chk("p4_acc", 32'(acc_a), 'h00);
        chk("p4_flags", 32'(flags_a), 'b11);

        // Reset during WAIT2 of the STA (11 edges after start)
        wr0 = wr_cnt_a;
        go_a(9'h0E0);
        tick(11);
        chk("mr_acc_pre", 32'(acc_a), 'hAA);
        rst_a = 1'b0;
        #1;
        chk("mr_acc", 32'(acc_a), 0);
        chk("mr_led", 32'(led_a), 0);
        chk("mr_raddr", 32'(raddr_a), 0);
        chk("mr_flags", 32'(flags_a), 0);
        tick(3);
        rst_a = 1'b1;
        tick(5);
        chk("mr_idle_led", 32'(led_a), 0);
        chk("mr_halted", 32'(halted_a), 0);
        chk("mr_writes", 32'(wr_cnt_a - wr0), 0);
        chk("mr_mem50", 32'(mem_a[9'h050]), 'h11);

        // 16/10/2 core: LDA# at 0x3FE/0x3FF, pc wraps to HLT at 0x000 (9+5)
        load_b(10'h3FE, 16'h0080);
        load_b(10'h3FF, 16'h00AB);
        load_b(10'h000, 16'h0000);
        go_b(10'h3FE);
        run_halt(1'b1, 200, cyc);
        chk("w_cycles", 32'(cyc), 14);
        chk("w_acc", 32'(acc_b), 'h00AB);
        chk("w_raddr", 32'(raddr_b), 'h001);

        // LDA# 1234 (9), LDA mem 0x40 (9 + 3 accesses), HLT (5)
        load_b(10'h000, 16'h0080);
        load_b(10'h001, 16'h1234);
        load_b(10'h002, 16'h0084);
        load_b(10'h003, 16'h0040);
        load_b(10'h004, 16'h0000);
        load_b(10'h040, 16'hBEEF);
        go_b(10'h000);
        tick(9);
        chk("b_acc_imm", 32'(acc_b), 'h1234);
        run_halt(1'b1, 200, cyc);
        chk("b_cycles", 32'(cyc), 17);
        chk("b_acc", 32'(acc_b), 'hBEEF);
        chk("b_flags", 32'(flags_b), 0);
        chk("b_halted", 32'(halted_b), 1);
        chk("b_raddr", 32'(raddr_b), 'h005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
